fwd_pipe: RTL and testbench

Parametrised post-decode pipeline tracker for the 5-stage RISC-V core. It carries destination tags and results from EX to WB over `DEPTH` stages, and forwards operands back to decode with youngest-match priority. It detects load-use hazards and generates the decode stall, inserting bubbles on stall or flush. It drives the register-file write port from its last stage, replacing the ad-hoc `ID_EX_*`/`EX_MEM_*`/`MEM_WB_*` register banks.

---
 rtl/fwd_pipe.sv | 152 +++++++++++++++
 tb/tb_fwd_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_pipe.sv
// Post-decode pipeline tracker: carries destination tags and results from EX to WB,
// forwards operands to decode with youngest-match priority and raises load-use stalls.
module fwd_pipe #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_we,
    input  logic            iss_load,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic            stall,
    output logic            ld_active,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data
);
    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] we_q, we_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [AW-1:0]    rd_q   [DEPTH];
    logic [AW-1:0]    rd_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic             flush_pend_q, flush_pend_d;

    logic [XLEN-1:0]  op_s  [2];
    logic [1:0]       haz_s;
    logic             hazard;
    logic             flush_eff;
    logic             issue_ok;

    // Scan oldest to youngest so the lowest matching stage is the last one to win.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [AW-1:0]   rs;
        logic [XLEN-1:0] rf;
        logic [XLEN-1:0] op;
        logic            haz;

        assign rs = (gi == 0) ? rs1 : rs2;
        assign rf = (gi == 0) ? rf_rdata1 : rf_rdata2;

        always_comb begin
            op  = rf;
            haz = 1'b0;
            if (rs == '0) begin
                op = '0;
            end else begin
                for (int k = LAST; k >= 0; k--) begin
                    if (v_q[k] && we_q[k] && (rd_q[k] == rs)) begin
                        haz = ld_q[k] && !rdy_q[k] && (k != LOAD_STAGE);
                        if (k == 0 && !ld_q[k]) begin
                            op = ex_result;
                        end else if (ld_q[k] && k == LOAD_STAGE) begin
                            op = ld_data;
                        end else begin
                            op = data_q[k];
                        end
                    end
                end
            end
        end

        assign op_s[gi]  = op;
        assign haz_s[gi] = haz;
    end

    assign op1       = op_s[0];
    assign op2       = op_s[1];
    assign hazard    = |haz_s;
    assign flush_eff = flush | flush_pend_q;
    assign issue_ok  = iss_valid & ~hazard & ~flush_eff;
    assign stall     = hold | (iss_valid & hazard);
    assign ld_active = v_q[LOAD_STAGE] & ld_q[LOAD_STAGE] & ~hold;
    assign wb_valid  = v_q[LAST] & we_q[LAST] & (rd_q[LAST] != '0) & ~hold;
    assign wb_rd     = rd_q[LAST];
    assign wb_data   = data_q[LAST];

    always_comb begin
        v_d          = v_q;
        we_d         = we_q;
        ld_d         = ld_q;
        rdy_d        = rdy_q;
        rd_d         = rd_q;
        data_d       = data_q;
        flush_pend_d = flush_pend_q;
        if (hold) begin
            if (flush) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            flush_pend_d = 1'b0;
            v_d[0]       = issue_ok;
            rd_d[0]      = iss_rd;
            we_d[0]      = iss_we;
            ld_d[0]      = iss_load;
            rdy_d[0]     = 1'b0;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]    = v_q[k-1];
                rd_d[k]   = rd_q[k-1];
                we_d[k]   = we_q[k-1];
                ld_d[k]   = ld_q[k-1];
                rdy_d[k]  = rdy_q[k-1];
                data_d[k] = data_q[k-1];
                // ALU results are captured leaving EX, load data leaving the load stage.
                if (k == 1 && !ld_q[0]) begin
                    data_d[k] = ex_result;
                    rdy_d[k]  = 1'b1;
                end else if (k - 1 == LOAD_STAGE && ld_q[k-1]) begin
                    data_d[k] = ld_data;
                    rdy_d[k]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q          <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            v_q          <= v_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Payload fields are meaningless while the matching valid bit is clear.
    always_ff @(posedge clk) begin
        we_q   <= we_d;
        ld_q   <= ld_d;
        rdy_q  <= rdy_d;
        rd_q   <= rd_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_fwd_pipe.sv
// Self-checking bench for fwd_pipe: directed scenarios plus randomized traffic
// compared against an instruction-level model of in-flight writes.
module tb_fwd_pipe;
    localparam int XLEN       = 32;
    localparam int AW         = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_we;
    logic            iss_load;
    logic            flush;
    logic            hold;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ld_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            stall;
    logic            ld_active;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    fwd_pipe #(
        .XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_we(iss_we),
        .iss_load(iss_load), .flush(flush), .hold(hold), .ex_result(ex_result),
        .ld_data(ld_data), .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .op1(op1), .op2(op2), .stall(stall),
        .ld_active(ld_active), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // Each accepted instruction has one final value; age = cycles since acceptance.
    typedef struct {
        logic [AW-1:0]   rd;
        logic            we;
        logic            ld;
        logic [XLEN-1:0] val;
        int              age;
    } ent_t;

    ent_t            pipe_q[$];
    logic [XLEN-1:0] rf_model [32];
    logic            flush_pend_m;
    int              checks = 0;
    int              errors = 0;

    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] exp_op1, exp_op2, exp_wbdata;
    logic [AW-1:0]   exp_wbrd;
    logic            exp_h1, exp_h2, exp_stall, exp_wbv, exp_lda;

    function automatic void lookup(input logic [AW-1:0] rs, input logic [XLEN-1:0] rf,
                                   output logic [XLEN-1:0] val, output logic haz);
        int best;
        best = -1;
        val  = rf;
        haz  = 1'b0;
        if (rs == '0) begin
            val = '0;
        end else begin
            foreach (pipe_q[i]) begin
                if (pipe_q[i].we && pipe_q[i].rd == rs &&
                    (best < 0 || pipe_q[i].age < pipe_q[best].age)) best = i;
            end
            if (best >= 0) begin
                val = pipe_q[best].val;
                haz = pipe_q[best].ld && (pipe_q[best].age < LOAD_STAGE);
            end
        end
    endfunction

    // Drive one cycle's inputs, derive expectations, then wait for the sampling edge.
    task automatic apply(input logic r, input logic v, input logic [AW-1:0] rd,
                         input logic we, input logic ld, input logic [XLEN-1:0] val,
                         input logic fl, input logic hd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        rst = r; iss_valid = v; iss_rd = rd; iss_we = we; iss_load = ld;
        flush = fl; hold = hd; rs1 = r1; rs2 = r2; new_val = val;
        ex_result  = $urandom;
        ld_data    = $urandom;
        exp_wbv    = 1'b0;
        exp_lda    = 1'b0;
        exp_wbrd   = '0;
        exp_wbdata = '0;
        foreach (pipe_q[i]) begin
            if (pipe_q[i].age == 0 && !pipe_q[i].ld) ex_result = pipe_q[i].val;
            if (pipe_q[i].age == LOAD_STAGE && pipe_q[i].ld) begin
                ld_data = pipe_q[i].val;
                exp_lda = !hd;
            end
            if (pipe_q[i].age == DEPTH - 1 && pipe_q[i].we && pipe_q[i].rd != '0) begin
                exp_wbv    = !hd;
                exp_wbrd   = pipe_q[i].rd;
                exp_wbdata = pipe_q[i].val;
            end
        end
        rf_rdata1 = (r1 == '0) ? XLEN'($urandom) : rf_model[r1];
        rf_rdata2 = (r2 == '0) ? XLEN'($urandom) : rf_model[r2];
        lookup(r1, rf_rdata1, exp_op1, exp_h1);
        lookup(r2, rf_rdata2, exp_op2, exp_h2);
        exp_stall = hd | (v & (exp_h1 | exp_h2));
        @(negedge clk);
    endtask

    task automatic advance();
        logic fe;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            pipe_q.delete();
            flush_pend_m = 1'b0;
        end else if (hold) begin
            if (flush) flush_pend_m = 1'b1;
        end else begin
            fe = flush | flush_pend_m;
            flush_pend_m = 1'b0;
            for (int i = pipe_q.size() - 1; i >= 0; i--) begin
                if (pipe_q[i].age == DEPTH - 1) begin
                    if (pipe_q[i].we && pipe_q[i].rd != '0) rf_model[pipe_q[i].rd] = pipe_q[i].val;
                    pipe_q.delete(i);
                end
            end
            foreach (pipe_q[i]) pipe_q[i].age++;
            if (iss_valid && !(exp_h1 || exp_h2) && !fe) begin
                e.rd = iss_rd; e.we = iss_we; e.ld = iss_load; e.val = new_val; e.age = 0;
                pipe_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            advance();
        end
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        advance();
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd0);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (ld_active !== 1'b0) begin errors++; $display("FAIL reset_ld_active: got %b expected 0", ld_active); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (op1 !== rf_model[3]) begin errors++; $display("FAIL reset_op1: got %h expected %h", op1, rf_model[3]); end
        checks++; if (op2 !== 32'd0) begin errors++; $display("FAIL reset_op2_x0: got %h expected 0", op2); end
        advance();
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd4);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hold: got %b expected 1", stall); end
        checks++; if (op2 !== rf_model[4]) begin errors++; $display("FAIL reset_op2: got %h expected %h", op2, rf_model[4]); end
        advance();
        $display("test_reset: done");
    endtask

    task automatic test_back_to_back();
        idle(3);
        apply(1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'd7, 1'b0, 1'b0, 5'd0, 5'd0);
        advance();
        apply(1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 32'd14, 1'b0, 1'b0, 5'd5, 5'd5);
        checks++; if (op1 !== 32'd7) begin errors++; $display("FAIL b2b_op1: got %h expected 7", op1); end
        checks++; if (op2 !== 32'd7) begin errors++; $display("FAIL b2b_op2: got %h expected 7", op2); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", stall); end
        advance();
        idle(1);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL b2b_wb_rd: got %0d expected 5", wb_rd); end
        checks++; if (wb_data !== 32'd7) begin errors++; $display("FAIL b2b_wb_data: got %h expected 7", wb_data); end
        advance();
        $display("test_back_to_back: done");
    endtask

    task automatic test_load_use();
        idle(3);
        apply(1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 5'd0, 5'd0);
        advance();
        apply(1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 5'd3, 5'd0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_first: got %b expected 1", stall); end
        advance();
        apply(1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 5'd3, 5'd0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_second: got %b expected 0", stall); end
        checks++; if (op1 !== 32'h0000_DEAD) begin errors++; $display("FAIL lu_op1: got %h expected 0000dead", op1); end
        checks++; if (ld_active !== 1'b1) begin errors++; $display("FAIL lu_ld_active: got %b expected 1", ld_active); end
        advance();
        $display("test_load_use: done");
    endtask

    task automatic test_youngest_wins();
        idle(3);
        for (int i = 1; i <= 3; i++) begin
            apply(1'b0, 1'b1, 5'd4, 1'b1, 1'b0, XLEN'(i), 1'b0, 1'b0, 5'd0, 5'd0);
            advance();
        end
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd4, 5'd4);
        checks++; if (op1 !== 32'd3) begin errors++; $display("FAIL youngest_op1: got %h expected 3", op1); end
        advance();
        $display("test_youngest_wins: done");
    endtask

    task automatic test_reg0();
        idle(3);
        apply(1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0);
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            checks++; if (op1 !== 32'd0) begin errors++; $display("FAIL reg0_op1: got %h expected 0", op1); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reg0_wb_valid: got %b expected 0", wb_valid); end
            advance();
        end
        $display("test_reg0: done");
    endtask

    task automatic test_hold_flush();
        idle(3);
        rf_model[10] = 32'h1010_1010;
        apply(1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 5'd0, 5'd0);
        advance();
        idle(2);
        for (int h = 0; h < 3; h++) begin
            apply(1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 32'hA5A5, (h == 1), 1'b1, 5'd0, 5'd0);
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL hold_wb_valid: got %b expected 0", wb_valid); end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b expected 1", stall); end
            advance();
        end
        apply(1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 32'hA5A5, 1'b0, 1'b0, 5'd0, 5'd0);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL release_wb_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_data !== 32'h99) begin errors++; $display("FAIL release_wb_data: got %h expected 99", wb_data); end
        advance();
        apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd10, 5'd0);
        checks++; if (op1 !== 32'h1010_1010) begin errors++; $display("FAIL release_bubble_op1: got %h expected 10101010", op1); end
        advance();
        $display("test_hold_flush: done");
    endtask

    task automatic test_reset_mid();
        idle(3);
        rf_model[11] = 32'h0BAD_0011;
        rf_model[13] = 32'h0BAD_0013;
        apply(1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 32'h111, 1'b0, 1'b0, 5'd0, 5'd0); advance();
        apply(1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 32'h222, 1'b0, 1'b0, 5'd0, 5'd0); advance();
        apply(1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 32'h333, 1'b0, 1'b0, 5'd0, 5'd0); advance();
        apply(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0); advance();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd11, 5'd13);
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wb_valid: got %b expected 0", wb_valid); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stall); end
            checks++; if (op1 !== 32'h0BAD_0011) begin errors++; $display("FAIL rstmid_op1: got %h expected 0bad0011", op1); end
            checks++; if (op2 !== 32'h0BAD_0013) begin errors++; $display("FAIL rstmid_op2: got %h expected 0bad0013", op2); end
            advance();
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        logic v, we, ld, fl, hd;
        logic [AW-1:0] rd, r1, r2;
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(3, 0) != 0);
            we = ($urandom_range(4, 0) != 0);
            ld = ($urandom_range(2, 0) == 0);
            fl = ($urandom_range(9, 0) == 0);
            hd = ($urandom_range(6, 0) == 0);
            rd = AW'($urandom_range(7, 0));
            r1 = AW'($urandom_range(7, 0));
            r2 = AW'($urandom_range(7, 0));
            apply(1'b0, v, rd, we, ld, XLEN'($urandom), fl, hd, r1, r2);
            $display("rand %0d: v=%b rd=%0d ld=%b fl=%b hd=%b rs=%0d/%0d op=%h/%h stall=%b wb=%b",
                     n, v, rd, ld, fl, hd, r1, r2, op1, op2, stall, wb_valid);
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rand_stall: got %b expected %b", stall, exp_stall); end
            checks++; if (ld_active !== exp_lda) begin errors++; $display("FAIL rand_ld_active: got %b expected %b", ld_active, exp_lda); end
            checks++; if (wb_valid !== exp_wbv) begin errors++; $display("FAIL rand_wb_valid: got %b expected %b", wb_valid, exp_wbv); end
            if (exp_wbv) begin
                checks++; if (wb_rd !== exp_wbrd) begin errors++; $display("FAIL rand_wb_rd: got %0d expected %0d", wb_rd, exp_wbrd); end
                checks++; if (wb_data !== exp_wbdata) begin errors++; $display("FAIL rand_wb_data: got %h expected %h", wb_data, exp_wbdata); end
            end
            if (!exp_h1) begin
                checks++; if (op1 !== exp_op1) begin errors++; $display("FAIL rand_op1: got %h expected %h", op1, exp_op1); end
            end
            if (!exp_h2) begin
                checks++; if (op2 !== exp_op2) begin errors++; $display("FAIL rand_op2: got %h expected %h", op2, exp_op2); end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; iss_we = 1'b0; iss_load = 1'b0;
        flush = 1'b0; hold = 1'b0; ex_result = '0; ld_data = '0; rs1 = '0; rs2 = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; new_val = '0; flush_pend_m = 1'b0;
        exp_h1 = 1'b0; exp_h2 = 1'b0;
        for (int i = 0; i < 32; i++) rf_model[i] = (i == 0) ? 32'd0 : XLEN'($urandom);
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest_wins();
        test_reg0();
        test_hold_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
